// File: rtl/uart_pkg.sv
// Shared types and constants for the parameterised UART transmitter.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

  // 100 MHz system clock, 115200 baud
  localparam int UART_DEFAULT_CLKS_PER_BIT = 868;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } uart_state_e;
`endif

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and pulses tick_o on the last count.
// clr_i holds the count at zero so a new bit period starts cleanly.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
  input  logic clk_i,
  input  logic arst_ni,
  input  logic clr_i,
  output logic tick_o
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = !clr_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr_i || tick_o) cnt_d = '0;
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_tx_param.sv
// Parameterised UART transmitter: start bit, DATA_W data bits LSB first, optional
// parity bit (compiled in with UART_TX_PARITY_EN), then STOP_BITS stop bits.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic              clk,
  input  logic              tx_arst_n,
  input  logic              tx_rst,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [DATA_W-1:0] data_in,
  output logic              busy,
  output logic              done,
  output logic              tx_bit
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] LAST_STOP = CNT_W'(STOP_BITS - 1);

  if (DATA_W < 5 || DATA_W > 9 || CLKS_PER_BIT < 2 || (STOP_BITS != 1 && STOP_BITS != 2) ||
      (PARITY_ODD != 0 && PARITY_ODD != 1)) begin : g_bad_param
    $error("uart_tx_param: illegal parameter value");
  end

  uart_state_e       state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              tx_bit_q, tx_bit_d;
  logic              ready_q;
  logic              tick;
  logic              accept;
`ifdef UART_TX_PARITY_EN
  logic              par_q, par_d;
`endif

  assign accept = tx_valid && tx_ready;
  assign tx_bit = tx_bit_q;

  // Baud counter idles at zero so the start bit gets a full period after acceptance
  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk_i  (clk),
    .arst_ni(tx_arst_n),
    .clr_i  (tx_rst || (state_q == ST_IDLE)),
    .tick_o (tick)
  );

  always_ff @(posedge clk or negedge tx_arst_n) begin
    if (!tx_arst_n) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_START;
      ST_START: if (tick) state_d = ST_DATA;
`ifdef UART_TX_PARITY_EN
      ST_DATA:   if (tick && bit_cnt_q == LAST_DATA) state_d = ST_PARITY;
      ST_PARITY: if (tick) state_d = ST_STOP;
`else
      ST_DATA:  if (tick && bit_cnt_q == LAST_DATA) state_d = ST_STOP;
`endif
      ST_STOP:  if (tick && bit_cnt_q == LAST_STOP) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (tx_rst) state_d = ST_IDLE;
  end

  // done is masked by tx_rst so an aborted frame never reports completion
  always_comb begin
    tx_ready = ready_q && !tx_rst && (state_q == ST_IDLE);
    busy     = (state_q != ST_IDLE);
    done     = !tx_rst && tick && (state_q == ST_STOP) && (bit_cnt_q == LAST_STOP);
  end

  // tx_bit_d is the line value for the bit that begins on the next cycle
  always_comb begin
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    tx_bit_d  = tx_bit_q;
`ifdef UART_TX_PARITY_EN
    par_d     = par_q;
`endif
    if (tx_rst) begin
      bit_cnt_d = '0;
      tx_bit_d  = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          tx_bit_d = 1'b1;
          if (accept) begin
            shreg_d   = data_in;
            bit_cnt_d = '0;
            tx_bit_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
            par_d     = (^data_in) ^ (PARITY_ODD != 0);
`endif
          end
        end
        ST_START: if (tick) tx_bit_d = shreg_q[0];
        ST_DATA: begin
          if (tick) begin
            if (bit_cnt_q == LAST_DATA) begin
              bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
              tx_bit_d  = par_q;
`else
              tx_bit_d  = 1'b1;
`endif
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
              shreg_d   = shreg_q >> 1;
              tx_bit_d  = shreg_q[1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: if (tick) tx_bit_d = 1'b1;
`endif
        ST_STOP: begin
          if (tick) begin
            tx_bit_d  = 1'b1;
            bit_cnt_d = (bit_cnt_q == LAST_STOP) ? '0 : bit_cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge tx_arst_n) begin
    if (!tx_arst_n) begin
      bit_cnt_q <= '0;
      tx_bit_q  <= 1'b1;
      ready_q   <= 1'b0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      tx_bit_q  <= tx_bit_d;
      ready_q   <= 1'b1;
    end
  end

  // Payload holds no control meaning, so it needs no reset
  always_ff @(posedge clk) begin
    shreg_q <= shreg_d;
`ifdef UART_TX_PARITY_EN
    par_q   <= par_d;
`endif
  end

endmodule
